// File: rtl/float_copro_master.sv
// float_copro_master
// Pipeline-side master for a floating-point coprocessor. It accepts one
// request, issues it to the coprocessor with a valid/complete handshake,
// waits for complete to drop again, then offers the captured result to the
// consumer with a valid/ready handshake.
//
// Optional feature: define COPRO_TIMEOUT_EN to add a 16-bit per-phase
// timeout counter. When it is undefined the block waits indefinitely in
// ISSUE and RELEASE and rsp_error stays 0.
module float_copro_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_opcode,
  input  logic [31:0] req_op0,
  input  logic [31:0] req_op1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_error,
  output logic        copro_valid,
  output logic [10:0] copro_opcode,
  output logic [31:0] copro_op0,
  output logic [31:0] copro_op1,
  input  logic        copro_complete,
  input  logic [31:0] copro_result,
  output logic        busy
);

  // Reject parameter values the 16-bit counter cannot represent.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("float_copro_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2,
    S_RESPOND = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic        copro_valid_q, copro_valid_d;
  logic [10:0] copro_opcode_q, copro_opcode_d;
  logic [31:0] copro_op0_q, copro_op0_d;
  logic [31:0] copro_op1_q, copro_op1_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_error_q, rsp_error_d;

  logic        accept;
  logic        timeout_hit;

  // A complete still high from an abandoned command keeps us from accepting.
  assign req_ready = (state_q == S_IDLE) && !copro_complete;
  assign busy      = (state_q != S_IDLE);
  assign accept    = req_valid && req_ready;

`ifdef COPRO_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] timeout_cnt_q, timeout_cnt_d;

  // The count that would be reached on this edge hitting the limit ends the phase.
  assign timeout_hit = ((timeout_cnt_q + 16'd1) == TIMEOUT_LIMIT);

  // Counter restarts on every state entry and only advances in the two wait phases.
  always_comb begin
    timeout_cnt_d = 16'd0;
    if ((state_d == state_q) && ((state_q == S_ISSUE) || (state_q == S_RELEASE))) begin
      timeout_cnt_d = timeout_cnt_q + 16'd1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_cnt_q <= 16'd0;
    end else begin
      timeout_cnt_q <= timeout_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: complete has priority over a same-cycle timeout.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (copro_complete || timeout_hit) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!copro_complete || timeout_hit) state_d = S_RESPOND;
      end
      S_RESPOND: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered command and response fields.
  always_comb begin
    copro_valid_d  = copro_valid_q;
    copro_opcode_d = copro_opcode_q;
    copro_op0_d    = copro_op0_q;
    copro_op1_d    = copro_op1_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_error_d    = rsp_error_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          copro_valid_d  = 1'b1;
          copro_opcode_d = req_opcode;
          copro_op0_d    = req_op0;
          copro_op1_d    = req_op1;
        end
      end
      S_ISSUE: begin
        if (copro_complete) begin
          copro_valid_d = 1'b0;
          rsp_result_d  = copro_result;
          rsp_error_d   = 1'b0;
        end else if (timeout_hit) begin
          copro_valid_d = 1'b0;
          rsp_result_d  = 32'd0;
          rsp_error_d   = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!copro_complete) begin
          rsp_valid_d = 1'b1;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end
      end
      S_RESPOND: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: begin
        copro_valid_d = 1'b0;
        rsp_valid_d   = 1'b0;
      end
    endcase
  end

  // Registered outputs; reset abandons any in-flight command silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      copro_valid_q  <= 1'b0;
      copro_opcode_q <= 11'd0;
      copro_op0_q    <= 32'd0;
      copro_op1_q    <= 32'd0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= 32'd0;
      rsp_error_q    <= 1'b0;
    end else begin
      copro_valid_q  <= copro_valid_d;
      copro_opcode_q <= copro_opcode_d;
      copro_op0_q    <= copro_op0_d;
      copro_op1_q    <= copro_op1_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_error_q    <= rsp_error_d;
    end
  end

  assign copro_valid  = copro_valid_q;
  assign copro_opcode = copro_opcode_q;
  assign copro_op0    = copro_op0_q;
  assign copro_op1    = copro_op1_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_error    = rsp_error_q;

endmodule

// File: tb/tb_float_copro_master.sv
// Testbench for float_copro_master. Inputs are driven and outputs sampled on
// the falling clock edge. The coprocessor is modelled either as a one-cycle
// registered responder (complete follows copro_valid by one edge) or driven
// directly by the scenario tasks.
module tb_float_copro_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_opcode;
  logic [31:0] req_op0;
  logic [31:0] req_op1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_error;
  logic        copro_valid;
  logic [10:0] copro_opcode;
  logic [31:0] copro_op0;
  logic [31:0] copro_op1;
  logic        copro_complete;
  logic [31:0] copro_result;
  logic        busy;

  logic manual_mode     = 1'b1;
  logic manual_complete = 1'b0;
  logic auto_complete   = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // One-cycle responder: complete is copro_valid delayed by one edge.
  always @(posedge clk) auto_complete <= copro_valid;
  assign copro_complete = manual_mode ? manual_complete : auto_complete;

  float_copro_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .copro_valid(copro_valid), .copro_opcode(copro_opcode),
    .copro_op0(copro_op0), .copro_op1(copro_op1),
    .copro_complete(copro_complete), .copro_result(copro_result),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Present a request and hold it until the edge that accepts it (bounded).
  task automatic send(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b,
                      output bit accepted);
    bit was_ready;
    accepted = 1'b0;
    req_opcode = op; req_op0 = a; req_op1 = b; req_valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      #1 was_ready = (req_ready === 1'b1);
      tick();
      accepted = was_ready;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max_cycles, output int n, output bit seen);
    seen = 1'b0; n = 0;
    while (!seen && n < max_cycles) begin
      tick();
      n++;
      seen = (rsp_valid === 1'b1);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, req_ready, copro_valid, rsp_valid, rsp_error} !== 5'b01000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 01000",
                         {busy, req_ready, copro_valid, rsp_valid, rsp_error});
    end
    n_checks++;
    if ({copro_opcode, copro_op0, copro_op1} !== 75'd0) begin
      n_fail++; $display("FAIL reset_cmd: got %h expected 0", {copro_opcode, copro_op0, copro_op1});
    end
    n_checks++;
    if (rsp_result !== 32'd0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 0", rsp_result);
    end
  endtask

  task automatic test_single_add();
    bit acc, seen; int n;
    manual_mode = 1'b0; rsp_ready = 1'b1; copro_result = 32'h4040_0000;
    send(11'h000, 32'h3F80_0000, 32'h4000_0000, acc);
    n_checks++;
    if (!acc) begin n_fail++; $display("FAIL add_accept: got 0 expected 1"); end
    n_checks++;
    if ({copro_valid, copro_opcode, copro_op0, copro_op1} !== {1'b1, 11'h000, 32'h3F80_0000, 32'h4000_0000}) begin
      n_fail++; $display("FAIL add_issue: got %h expected %h",
                         {copro_valid, copro_opcode, copro_op0, copro_op1},
                         {1'b1, 11'h000, 32'h3F80_0000, 32'h4000_0000});
    end
    wait_rsp(20, n, seen);
    n_checks++;
    if (!seen || n != 4) begin n_fail++; $display("FAIL add_latency: got %0d (seen %0d) expected 4", n, seen); end
    n_checks++;
    if ({rsp_result, rsp_error} !== {32'h4040_0000, 1'b0}) begin
      n_fail++; $display("FAIL add_result: got %h/%b expected 40400000/0", rsp_result, rsp_error);
    end
    tick();
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL add_done: got %b expected 00", {rsp_valid, busy});
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int accepts[$]; int rsps; bit was_ready, seen; int n;
    manual_mode = 1'b0; rsp_ready = 1'b1; copro_result = 32'h1234_5678;
    req_opcode = 11'h002; req_op0 = 32'h4110_0000; req_op1 = 32'h4040_0000; req_valid = 1'b1;
    rsps = 0;
    for (int cyc = 0; cyc < 40 && accepts.size() < 2; cyc++) begin
      #1 was_ready = (req_ready === 1'b1);
      tick();
      if (was_ready) accepts.push_back(cyc);
      if (rsp_valid === 1'b1) rsps++;
    end
    req_valid = 1'b0;
    n_checks++;
    if (accepts.size() != 2) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", accepts.size());
    end else begin
      n_checks++;
      if (accepts[1] - accepts[0] < 5) begin
        n_fail++; $display("FAIL b2b_gap: got %0d expected >= 5", accepts[1] - accepts[0]);
      end
    end
    n_checks++;
    if (rsps != 1) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d expected 1", rsps); end
    wait_rsp(20, n, seen);
    n_checks++;
    if (!seen || rsp_result !== 32'h1234_5678) begin
      n_fail++; $display("FAIL b2b_second: got %h (seen %0d) expected 12345678", rsp_result, seen);
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  // Random requests against a responder with random delays; the expected
  // behaviour follows the handshake rules directly.
  task automatic test_random();
    logic [10:0] op; logic [31:0] a, b, r; int d, h, w; bit acc;
    manual_mode = 1'b1; manual_complete = 1'b0; rsp_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      op = 11'($urandom_range(0, 2047)); a = $urandom; b = $urandom; r = $urandom;
      d = $urandom_range(0, 4); h = $urandom_range(0, 3); w = $urandom_range(0, 3);
      send(op, a, b, acc);
      n_checks++;
      if (!acc) begin n_fail++; $display("FAIL rand%0d_accept: got 0 expected 1", t); end
      for (int i = 0; i <= d; i++) begin
        n_checks++;
        if ({copro_valid, copro_opcode, copro_op0, copro_op1, rsp_valid} !== {1'b1, op, a, b, 1'b0}) begin
          n_fail++; $display("FAIL rand%0d_issue: got %h expected %h", t,
                             {copro_valid, copro_opcode, copro_op0, copro_op1, rsp_valid},
                             {1'b1, op, a, b, 1'b0});
        end
        if (i < d) tick();
      end
      manual_complete = 1'b1; copro_result = r;
      tick();
      n_checks++;
      if ({copro_valid, rsp_valid, busy} !== 3'b001) begin
        n_fail++; $display("FAIL rand%0d_release: got %b expected 001", t, {copro_valid, rsp_valid, busy});
      end
      for (int i = 0; i < h; i++) begin
        copro_result = $urandom;
        tick();
        n_checks++;
        if ({copro_valid, rsp_valid} !== 2'b00) begin
          n_fail++; $display("FAIL rand%0d_hold: got %b expected 00", t, {copro_valid, rsp_valid});
        end
      end
      manual_complete = 1'b0; copro_result = $urandom;
      tick();
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_error} !== {1'b1, r, 1'b0}) begin
        n_fail++; $display("FAIL rand%0d_rsp: got %h expected %h", t,
                           {rsp_valid, rsp_result, rsp_error}, {1'b1, r, 1'b0});
      end
      for (int i = 0; i < w; i++) begin
        tick();
        n_checks++;
        if ({rsp_valid, rsp_result} !== {1'b1, r}) begin
          n_fail++; $display("FAIL rand%0d_stall: got %h expected %h", t, {rsp_valid, rsp_result}, {1'b1, r});
        end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
        n_fail++; $display("FAIL rand%0d_done: got %b expected 00", t, {rsp_valid, busy});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; bit acc, seen; int n;
    manual_mode = 1'b0; rsp_ready = 1'b0; r = $urandom; copro_result = r;
    send(11'h001, $urandom, $urandom, acc);
    wait_rsp(20, n, seen);
    n_checks++;
    if (!acc || !seen) begin n_fail++; $display("FAIL bp_rsp: got acc %0d seen %0d expected 1 1", acc, seen); end
    // A second requester waits meanwhile; it must not disturb anything.
    req_opcode = 11'h7A5; req_op0 = 32'hDEAD_BEEF; req_op1 = 32'h0BAD_F00D; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({rsp_valid, rsp_result, req_ready, copro_valid} !== {1'b1, r, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL bp_stall%0d: got %h expected %h", i,
                           {rsp_valid, rsp_result, req_ready, copro_valid}, {1'b1, r, 1'b0, 1'b0});
      end
    end
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL bp_idle: got %b expected 00", {busy, rsp_valid});
    end
    r = $urandom; copro_result = r;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({copro_valid, copro_opcode, copro_op0} !== {1'b1, 11'h7A5, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL bp_next_issue: got %h expected %h",
                         {copro_valid, copro_opcode, copro_op0}, {1'b1, 11'h7A5, 32'hDEAD_BEEF});
    end
    wait_rsp(20, n, seen);
    n_checks++;
    if (!seen || n != 4 || rsp_result !== r) begin
      n_fail++; $display("FAIL bp_next_rsp: got %h after %0d expected %h after 4", rsp_result, n, r);
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_ignore_complete();
    logic [31:0] r; bit acc;
    manual_mode = 1'b1; manual_complete = 1'b0; rsp_ready = 1'b0; r = $urandom;
    send(11'h003, $urandom, $urandom, acc);
    manual_complete = 1'b1; copro_result = r;
    tick();
    manual_complete = 1'b0; copro_result = ~r;
    tick();
    n_checks++;
    if ({acc, rsp_valid, rsp_result} !== {2'b11, r}) begin
      n_fail++; $display("FAIL ign_rsp: got %h expected %h", {acc, rsp_valid, rsp_result}, {2'b11, r});
    end
    manual_complete = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({rsp_valid, busy, rsp_result} !== {2'b11, r}) begin
        n_fail++; $display("FAIL ign_respond%0d: got %h expected %h", i, {rsp_valid, busy, rsp_result}, {2'b11, r});
      end
    end
    manual_complete = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; manual_complete = 1'b1; copro_result = $urandom;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({busy, rsp_valid, copro_valid, rsp_result} !== {3'b000, r}) begin
        n_fail++; $display("FAIL ign_idle%0d: got %h expected %h", i,
                           {busy, rsp_valid, copro_valid, rsp_result}, {3'b000, r});
      end
    end
    manual_complete = 1'b0;
  endtask

  task automatic test_stale_complete();
    logic [31:0] r; bit acc;
    manual_mode = 1'b1; manual_complete = 1'b1; r = $urandom;
    do_reset();
    req_opcode = 11'h002; req_op0 = $urandom; req_op1 = $urandom; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stale_ready%0d: got %b expected 0", i, req_ready); end
      tick();
      n_checks++;
      if ({busy, copro_valid} !== 2'b00) begin
        n_fail++; $display("FAIL stale_idle%0d: got %b expected 00", i, {busy, copro_valid});
      end
    end
    req_valid = 1'b0; manual_complete = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL stale_ready_clear: got %b expected 1", req_ready); end
    send(11'h002, req_op0, req_op1, acc);
    n_checks++;
    if ({acc, copro_valid, busy} !== 3'b111) begin
      n_fail++; $display("FAIL stale_accept: got %b expected 111", {acc, copro_valid, busy});
    end
    manual_complete = 1'b1; copro_result = r;
    tick();
    manual_complete = 1'b0;
    tick();
    n_checks++;
    if ({rsp_valid, rsp_result} !== {1'b1, r}) begin
      n_fail++; $display("FAIL stale_rsp: got %h expected %h", {rsp_valid, rsp_result}, {1'b1, r});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit acc, seen; int n; logic [31:0] r;
    manual_mode = 1'b1; manual_complete = 1'b0; rsp_ready = 1'b0;
    send(11'h003, 32'h4080_0000, 32'h3F00_0000, acc);
    tick(); tick();
    n_checks++;
    if ({acc, copro_valid, copro_opcode} !== {2'b11, 11'h003}) begin
      n_fail++; $display("FAIL rmid_issue: got %h expected %h", {acc, copro_valid, copro_opcode}, {2'b11, 11'h003});
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({copro_valid, busy, rsp_valid, copro_opcode, copro_op0, copro_op1} !== 78'd0) begin
      n_fail++; $display("FAIL rmid_cleared: got %h expected 0",
                         {copro_valid, busy, rsp_valid, copro_opcode, copro_op0, copro_op1});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
        n_fail++; $display("FAIL rmid_no_rsp%0d: got %b expected 00", i, {rsp_valid, busy});
      end
    end
    manual_mode = 1'b0; rsp_ready = 1'b1; r = $urandom; copro_result = r;
    send(11'h003, $urandom, $urandom, acc);
    wait_rsp(20, n, seen);
    n_checks++;
    if (!acc || !seen || n != 4 || {rsp_result, rsp_error} !== {r, 1'b0}) begin
      n_fail++; $display("FAIL rmid_next: got %h after %0d expected %h after 4", rsp_result, n, r);
    end
    tick();
    rsp_ready = 1'b0;
  endtask

`ifdef COPRO_TIMEOUT_EN
  task automatic test_timeout();
    bit acc; logic [31:0] r;
    manual_mode = 1'b1; manual_complete = 1'b0; rsp_ready = 1'b0;
    send(11'h000, $urandom, $urandom, acc);
    for (int k = 1; k <= TO; k++) begin
      tick();
      n_checks++;
      if (copro_valid !== ((k < TO) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL to_issue_k%0d: got %b expected %b", k, copro_valid, (k < TO));
      end
    end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_error, rsp_result} !== {2'b11, 32'd0}) begin
      n_fail++; $display("FAIL to_issue_rsp: got %h expected %h", {rsp_valid, rsp_error, rsp_result}, {2'b11, 32'd0});
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    r = $urandom;
    send(11'h001, $urandom, $urandom, acc);
    manual_complete = 1'b1; copro_result = r;
    tick();
    for (int k = 1; k <= TO; k++) begin
      tick();
      n_checks++;
      if (rsp_valid !== ((k == TO) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL to_release_k%0d: got %b expected %b", k, rsp_valid, (k == TO));
      end
    end
    n_checks++;
    if ({rsp_error, rsp_result} !== {1'b1, r}) begin
      n_fail++; $display("FAIL to_release_rsp: got %h expected %h", {rsp_error, rsp_result}, {1'b1, r});
    end
    manual_complete = 1'b0; rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    bit acc; logic [31:0] r; bit ok;
    manual_mode = 1'b1; manual_complete = 1'b0; rsp_ready = 1'b0; r = $urandom;
    send(11'h002, $urandom, $urandom, acc);
    ok = acc;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ({copro_valid, busy, rsp_valid} !== 3'b110) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL noto_issue_wait: got early exit expected wait"); end
    manual_complete = 1'b1; copro_result = r;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ({copro_valid, busy, rsp_valid} !== 3'b010) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL noto_release_wait: got early exit expected wait"); end
    manual_complete = 1'b0;
    tick();
    n_checks++;
    if ({rsp_valid, rsp_error, rsp_result} !== {2'b10, r}) begin
      n_fail++; $display("FAIL noto_rsp: got %h expected %h", {rsp_valid, rsp_error, rsp_result}, {2'b10, r});
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = '0; req_op0 = '0; req_op1 = '0; copro_result = '0;
    do_reset();
    test_reset();
    test_single_add();
    test_back_to_back();
    test_random();
    test_backpressure();
    test_ignore_complete();
    test_stale_complete();
    test_reset_mid();
`ifdef COPRO_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
